// File: rtl/tap_pkg.sv
// Shared event codes and FSM encoding for the tap classifier.
package tap_pkg;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SINGLE = 2'b01;
  localparam logic [1:0] EVT_DOUBLE = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    WAIT2 = 1'b1
  } state_t;

  typedef struct packed {
    logic       push;
    logic [1:0] code;
  } evt_req_t;

endpackage

// File: rtl/evt_fifo.sv
// Registered synchronous FIFO; head is visible the cycle after the push edge (no bypass).
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tap_classifier.sv
// Classifies press pulses as SINGLE/DOUBLE taps within a programmable window and
// queues the events for a valid/ready consumer; sticky overflow on dropped events.
module tap_classifier
  import tap_pkg::*;
#(
  parameter int WINDOW = 25_000_000,
  parameter int CNT_W  = $clog2(WINDOW),
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_code,
  output logic       busy,
  output logic       overflow
);

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  evt_req_t   req;
  logic       timeout;
  logic       pop, fifo_empty, fifo_full, drop;
  logic [1:0] fifo_dout;

  assign timeout = (cnt_q == CNT_W'(WINDOW - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (press) state_d = WAIT2;
      WAIT2:   if (press || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Press beats timeout when both land on the last window cycle.
  always_comb begin
    req   = '{push: 1'b0, code: EVT_NONE};
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (press) cnt_d = '0;
      WAIT2: begin
        if (press)        req = '{push: 1'b1, code: EVT_DOUBLE};
        else if (timeout) req = '{push: 1'b1, code: EVT_SINGLE};
        else              cnt_d = cnt_q + CNT_W'(1);
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign busy      = (state_q == WAIT2);
  assign evt_valid = ~fifo_empty;
  assign evt_code  = evt_valid ? fifo_dout : EVT_NONE;
  assign pop       = evt_valid & evt_ready;
  assign drop      = req.push & fifo_full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  evt_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req.push),
    .din   (req.code),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_tap_classifier.sv
// Bench for tap_classifier with WINDOW=8, DEPTH=4: gesture table plus scoreboard of popped codes.
module tb_tap_classifier;

  logic       clk = 1'b0;
  logic       rst, press, evt_ready;
  logic       evt_valid, busy, overflow;
  logic [1:0] evt_code;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    int         gap;     // edges from first to second press; 0 = no second press
    logic [1:0] code;
    int         edge_n;  // edges after first press at which the event appears
  } vec_t;
  vec_t vecs[4];

  tap_classifier #(.WINDOW(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .press     (press),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a pop happens at the next edge, so compare the head now.
  always @(negedge clk) begin : mon
    logic [1:0] e;
    if (rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got code %0h expected no event", evt_code);
      end else begin
        e = exp_q.pop_front();
        chk("pop_code", {30'd0, evt_code}, {30'd0, e});
      end
    end
  end

  // One gesture with evt_ready low; FIFO must have room for the result.
  task automatic gesture(input int gap, input logic [1:0] code, input int edge_n);
    press = 1'b1;
    step();
    press = 1'b0;
    chk("busy_start", busy, 1);
    for (int k = 1; k <= edge_n; k++) begin
      if (k == gap) press = 1'b1;
      step();
      press = 1'b0;
      if (k < edge_n) begin
        chk("busy_mid", busy, 1);
        chk("valid_mid", evt_valid, (exp_q.size() != 0));
      end
    end
    exp_q.push_back(code);
    chk("busy_end", busy, 0);
    chk("valid_end", evt_valid, 1);
    chk("head_code", {30'd0, evt_code}, {30'd0, exp_q[0]});
  endtask

  task automatic drain(input int n);
    evt_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", evt_valid, 1);
      step();
    end
    evt_ready = 1'b0;
    chk("drain_empty", evt_valid, 0);
    chk("drain_code0", {30'd0, evt_code}, 32'd0);
    chk("drain_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{gap: 1, code: 2'b10, edge_n: 1};
    vecs[1] = '{gap: 4, code: 2'b10, edge_n: 4};
    vecs[2] = '{gap: 8, code: 2'b10, edge_n: 8};  // press on counter = 7 ties with timeout
    vecs[3] = '{gap: 0, code: 2'b01, edge_n: 8};

    rst = 1'b0; press = 1'b0; evt_ready = 1'b0;
    #2;
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", {30'd0, evt_code}, 32'd0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    press = 1'b1;
    step(); step();
    chk("rst_busy_press", busy, 0);
    press = 1'b0;
    rst = 1'b1;

    // Ready while empty must not disturb anything.
    evt_ready = 1'b1;
    step(); step();
    evt_ready = 1'b0;
    chk("ready_empty_valid", evt_valid, 0);

    for (int v = 0; v < 4; v++) begin
      gesture(vecs[v].gap, vecs[v].code, vecs[v].edge_n);
      drain(1);
    end

    // Press right after a timeout starts a fresh gesture.
    gesture(0, 2'b01, 8);
    press = 1'b1;
    step();
    press = 1'b0;
    chk("regesture_busy", busy, 1);
    chk("regesture_head", {30'd0, evt_code}, 32'd1);
    press = 1'b1;
    step();
    press = 1'b0;
    exp_q.push_back(2'b10);
    chk("regesture_done", busy, 0);
    drain(2);

    // Asynchronous reset mid-gesture with an event buffered.
    gesture(1, 2'b10, 1);
    press = 1'b1;
    step();
    press = 1'b0;
    step(); step();
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", evt_valid, 0);
    chk("arst_code", {30'd0, evt_code}, 32'd0);
    exp_q.delete();
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_rst_valid", evt_valid, 0);
      chk("post_rst_busy", busy, 0);
    end

    // Full FIFO plus simultaneous pop: push accepted, no overflow.
    gesture(0, 2'b01, 8);
    for (int i = 0; i < 3; i++) gesture(1, 2'b10, 1);
    chk("full_ovf0", overflow, 0);
    press = 1'b1;
    step();
    evt_ready = 1'b1;
    exp_q.push_back(2'b10);
    step();
    press = 1'b0;
    evt_ready = 1'b0;
    chk("fullpop_ovf", overflow, 0);
    chk("fullpop_head", {30'd0, evt_code}, 32'd2);
    drain(4);

    // Five back-to-back doubles with no consumer: fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      press = 1'b1;
      step(); step();
      press = 1'b0;
      if (i < 4) exp_q.push_back(2'b10);
      chk("ovf_flag", overflow, (i == 4));
    end
    chk("ovf_head", {30'd0, evt_code}, 32'd2);
    drain(4);
    step(); step();
    chk("ovf_sticky", overflow, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
